// File: rtl/add_seq_pkg.sv
// Shared types and sizing helpers for the byte-serial adder sequencer.
package add_seq_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of byte steps needed for a given operand width.
  function automatic int nb_of(input int width);
    return width / BYTE_W;
  endfunction

  // Byte index width, kept at least one bit so WIDTH=8 still has a register.
  function automatic int idx_w_of(input int width);
    int nb;
    nb = width / BYTE_W;
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/adder8_cin.sv
// Combinational 8-bit adder slice with carry in/out, built as a ripple of
// 1-bit full adders.
module adder8_cin
  import add_seq_pkg::*;
(
  input  logic [BYTE_W-1:0] a,
  input  logic [BYTE_W-1:0] b,
  input  logic              cin,
  output logic [BYTE_W-1:0] sum,
  output logic              cout
);

  logic carry_chain;

  // Ripple the carry through one full adder per bit.
  always_comb begin
    sum         = '0;
    carry_chain = cin;
    for (int i = 0; i < BYTE_W; i++) begin
      sum[i]      = a[i] ^ b[i] ^ carry_chain;
      carry_chain = (a[i] & b[i]) | (carry_chain & (a[i] ^ b[i]));
    end
  end

  assign cout = carry_chain;

endmodule

// File: rtl/add_seq_ctrl.sv
// Byte-serial WIDTH-bit adder: one 8-bit slice reused over WIDTH/8 cycles,
// LSB byte first, with valid/ready handshakes on both sides.
// Optional subtract mode is built when ADD_SEQ_SUB_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | in_ready=1, waiting for operands
// CALC  | one byte per edge through the slice, carry held in carry_q
// DONE  | out_valid=1, sum/cout held until out_ready
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NB    = nb_of(WIDTH);
  localparam int IDX_W = idx_w_of(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NB - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;

  logic [BYTE_W-1:0]  slice_a, slice_b, slice_sum;
  logic               slice_cout;

`ifdef ADD_SEQ_SUB_EN
  logic               op_q, op_d;
`else
  logic               unused_op;
  assign unused_op = op;
`endif

  // Pick the current operand bytes; b is inverted in subtract mode.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NB; i++) begin
      if (idx_q == IDX_W'(i)) begin
        slice_a = a_q[i*BYTE_W +: BYTE_W];
        slice_b = b_q[i*BYTE_W +: BYTE_W];
      end
    end
`ifdef ADD_SEQ_SUB_EN
    if (op_q) slice_b = ~slice_b;
`endif
  end

  adder8_cin u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state, operand capture and per-byte result update.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef ADD_SEQ_SUB_EN
    op_d    = op_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          idx_d   = '0;
          carry_d = cin;
`ifdef ADD_SEQ_SUB_EN
          op_d    = op;
          if (op) carry_d = 1'b1;
`endif
          state_d = CALC;
        end
      end
      CALC: begin
        for (int i = 0; i < NB; i++) begin
          if (idx_q == IDX_W'(i)) sum_d[i*BYTE_W +: BYTE_W] = slice_sum;
        end
        carry_d = slice_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = slice_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_SEQ_SUB_EN
      op_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef ADD_SEQ_SUB_EN
      op_q    <= op_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed bench for add_seq_ctrl: WIDTH=32 instance for the vector table and
// corner sequences, plus a WIDTH=8 instance for the throughput case.
module tb_add_seq_ctrl;

  logic        clk;
  logic        rst_n;

  logic        in_valid, in_ready, cin, op, out_valid, out_ready, cout;
  logic [31:0] a, b, sum;

  logic        in_valid8, in_ready8, cin8, op8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;

  int n_total;
  int n_pass;

  add_seq_ctrl #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op(op),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout)
  );

  add_seq_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8), .op(op8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        op;
    logic [31:0] exp_sum;
    logic        exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vcin,
                        input logic vop, input logic [31:0] es, input logic ec,
                        input string tag);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_ready"}, in_ready, 1);
    a = va; b = vb; cin = vcin; op = vop; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; cin = 1'b0; op = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, {in_ready, out_valid}, 2'b10);
  endtask

  task automatic stream(input bit w8);
    logic [31:0] sa[4];
    logic [31:0] sb[4];
    logic        sc[4];
    int          acc_edge[4];
    int          ni, no, cyc, step;
    bit          acc;
    logic [32:0] ex;
    logic [31:0] mask, rs;
    logic        rc;
    string       tag;
    sa = '{32'hFFFF_FFFF, 32'h0000_8001, 32'hDEAD_BEEF, 32'h7F7F_7F7F};
    sb = '{32'h0000_0001, 32'h7FFF_FFFF, 32'h1234_5678, 32'h8181_8181};
    sc = '{1'b0, 1'b1, 1'b0, 1'b1};
    step = w8 ? 3 : 6;
    mask = w8 ? 32'h0000_00FF : 32'hFFFF_FFFF;
    tag  = w8 ? "stream8" : "stream32";
    ni = 0; no = 0; cyc = 0;
    for (int i = 0; i < 4; i++) acc_edge[i] = 0;
    if (w8) begin
      a8 = sa[0][7:0]; b8 = sb[0][7:0]; cin8 = sc[0]; in_valid8 = 1'b1;
    end else begin
      a = sa[0]; b = sb[0]; cin = sc[0]; op = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    end
    while (no < 4 && cyc < 200) begin
      acc = w8 ? in_ready8 : in_ready;
      if (w8 ? out_valid8 : out_valid) begin
        ex = {1'b0, sa[no] & mask} + {1'b0, sb[no] & mask} + {32'd0, sc[no]};
        rs = w8 ? {24'd0, sum8} : sum;
        rc = w8 ? cout8 : cout;
        chk($sformatf("%s_sum%0d", tag, no), rs, ex[31:0] & mask);
        chk($sformatf("%s_cout%0d", tag, no), rc, w8 ? ex[8] : ex[32]);
        no++;
      end
      @(posedge clk); #1; cyc++;
      if (acc && ni < 4) begin
        acc_edge[ni] = cyc;
        ni++;
        if (ni < 4) begin
          if (w8) begin a8 = sa[ni][7:0]; b8 = sb[ni][7:0]; cin8 = sc[ni]; end
          else begin a = sa[ni]; b = sb[ni]; cin = sc[ni]; end
        end else begin
          if (w8) in_valid8 = 1'b0; else in_valid = 1'b0;
        end
      end
    end
    chk({tag, "_done_in_time"}, no, 4);
    for (int i = 1; i < 4; i++)
      chk($sformatf("%s_interval%0d", tag, i), acc_edge[i] - acc_edge[i-1], step);
    @(posedge clk); #1;
    if (!w8) out_ready = 1'b0;
  endtask

  initial begin
    int n;
    n_total = 0;
    n_pass  = 0;

    vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0001, 1'b0};
`ifdef ADD_SEQ_SUB_EN
    vecs[6] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0};
    vecs[7] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
`else
    vecs[6] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'h0000_000C, 1'b0};
    vecs[7] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_000D, 1'b0};
`endif

    rst_n = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0; out_ready = 1'b0;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; op8 = 1'b0; out_ready8 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_sum", sum, 0);
    chk("reset_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++)
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].op,
             vecs[i].exp_sum, vecs[i].exp_cout, $sformatf("vec%0d", i));

    // Backpressure: result held while new operands are offered.
    a = 32'h0F0F_0F0F; b = 32'h0101_0101; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("bp_latency", n, 4);
    a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; cin = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_out_valid%0d", k), out_valid, 1);
      chk($sformatf("bp_in_ready%0d", k), in_ready, 0);
      chk($sformatf("bp_sum%0d", k), sum, 32'h1010_1010);
      chk($sformatf("bp_cout%0d", k), cout, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_release", {in_ready, out_valid}, 2'b10);
    @(posedge clk); #1;
    chk("bp_no_capture", {in_ready, out_valid}, 2'b10);

    // Reset in the middle of CALC.
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_busy", in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(32'd1, 32'd2, 1'b0, 1'b0, 32'd3, 1'b0, "post_reset");

    stream(1'b0);
    stream(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
